usb_rx_ctrl: RTL



---
 rtl/usb_rx_pkg.sv | 38 +++
 rtl/usb_rx_ctrl_timer.sv | 50 +++++
 rtl/usb_rx_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
// Shared definitions for the full-speed USB receive controller:
//   - rx_state_t  : receive FSM state encoding
//   - SYNC_BYTE   : expected SYNC pattern after NRZI decode (LSB first)
//   - STUFF_LIMIT : run of consecutive ones after which a zero is stuffed
//   - PID_*       : PID type nibbles (low half of the PID byte)
//   - pid_valid() : PID byte check field test
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_PID   = 3'd2,
        ST_DATA  = 3'd3,
        ST_EOP1  = 3'd4,
        ST_EOP2  = 3'd5,
        ST_ERROR = 3'd6
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    // The upper nibble of a PID byte is the one's complement of the type nibble.
    function automatic logic pid_valid(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_ctrl_timer.sv
// usb_bit_timer
// Bit-time counter for the receiver. Counts 0..CLKS_PER_BIT-1 while the
// receiver is active, is held at 0 when inactive, and is reloaded to 0 the
// clock after any line transition so sampling stays centred on the bit.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   active_i         receiver is out of IDLE
//   d_edge_i         one-cycle strobe on a D+ transition
//   shift_enable_o   bit-sample strobe (decoded from the registered count)
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic d_edge_i,
    output logic shift_enable_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || d_edge_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An edge in the sampling cycle does not suppress this strobe; the
    // reload only shows up in the following cycle.
    assign shift_enable_o = active_i && (cnt_q == SAMPLE_CNT);

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl
// Full-speed USB receive controller: owns bit timing, strips stuffed bits,
// assembles LSB-first bytes, validates SYNC and PID, and writes data bytes
// to the RX FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   d_edge          one-cycle strobe on any D+ transition
//   d_orig          decoded NRZI bit, valid on shift_enable
//   eop             SE0 indication, valid on shift_enable
//   shift_enable    bit-sample strobe to the decoder and this block
//   rcving          packet reception in progress
//   rx_pid          PID type nibble of the current packet
//   rx_data         received data byte
//   w_enable        one-cycle FIFO write strobe for rx_data
//   rx_packet_done  one-cycle pulse on a clean end of packet
//   rx_error        sticky packet error flag (cleared at next packet start)
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       d_orig,
    input  logic       eop,
    output logic       shift_enable,
    output logic       rcving,
    output logic [3:0] rx_pid,
    output logic [7:0] rx_data,
    output logic       w_enable,
    output logic       rx_packet_done,
    output logic       rx_error
);

    rx_state_t  state_q, state_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] rx_pid_q, rx_pid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       w_en_q, w_en_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       err_se0_q, err_se0_d;   // ERROR has seen its SE0 bit
    logic       se;
    logic [7:0] byte_full;

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .active_i       (state_q != ST_IDLE),
        .d_edge_i       (d_edge),
        .shift_enable_o (se)
    );

    // Byte as it stands once the current bit is shifted in.
    assign byte_full = {d_orig, shreg_q[7:1]};

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        rx_pid_d  = rx_pid_q;
        rx_data_d = rx_data_q;
        w_en_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        err_se0_d = err_se0_q;

        case (state_q)
            ST_IDLE: begin
                ones_d    = '0;
                idx_d     = '0;
                shreg_d   = '0;
                err_se0_d = 1'b0;
                if (d_edge) begin
                    state_d = ST_SYNC;
                    err_d   = 1'b0;
                end
            end

            ST_SYNC, ST_PID, ST_DATA: begin
                if (se) begin
                    if (eop) begin
                        // SE0 is only a legal packet end on a byte boundary after SYNC.
                        if (state_q != ST_SYNC && idx_q == 3'd0) begin
                            state_d = ST_EOP1;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else if (ones_q == 3'(STUFF_LIMIT)) begin
                        if (d_orig) begin
                            state_d = ST_ERROR;
                        end else begin
                            ones_d = '0;    // stuffed zero: dropped, no shift
                        end
                    end else begin
                        ones_d  = d_orig ? (ones_q + 3'd1) : 3'd0;
                        shreg_d = byte_full;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            case (state_q)
                                ST_SYNC: state_d = (byte_full == SYNC_BYTE) ? ST_PID : ST_ERROR;
                                ST_PID: begin
                                    if (pid_valid(byte_full)) begin
                                        rx_pid_d = byte_full[3:0];
                                        state_d  = ST_DATA;
                                    end else begin
                                        state_d = ST_ERROR;
                                    end
                                end
                                default: begin
                                    rx_data_d = byte_full;
                                    w_en_d    = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end

            ST_EOP1: begin
                if (se) begin
                    state_d = eop ? ST_EOP2 : ST_ERROR;
                end
            end

            ST_EOP2: begin
                // Extra SE0 bits are tolerated; J ends the packet.
                if (se && !eop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_ERROR: begin
                // Resynchronise on the line: an SE0 bit followed by a J bit.
                if (se) begin
                    if (!err_se0_q) begin
                        if (eop) begin
                            err_se0_d = 1'b1;
                        end
                    end else if (!eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERROR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ones_q    <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            rx_pid_q  <= '0;
            rx_data_q <= '0;
            w_en_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_se0_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            rx_pid_q  <= rx_pid_d;
            rx_data_q <= rx_data_d;
            w_en_q    <= w_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_se0_q <= err_se0_d;
        end
    end

    assign shift_enable   = se;
    assign rcving         = (state_q != ST_IDLE);
    assign rx_pid         = rx_pid_q;
    assign rx_data        = rx_data_q;
    assign w_enable       = w_en_q;
    assign rx_packet_done = done_q;
    assign rx_error       = err_q;

endmodule
